load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits between the core's execute stage and the word-organised data memory. Translates RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-wide memory reads and writes, and sign- or zero-extends load data. Sub-word stores use a two-cycle read-modify-write. Drives `stall` so the single-cycle core freezes its PC while an access is in flight. Flags misaligned, illegal and out-of-range accesses.

Parameters:
- MEM_WORDS, 64, data memory depth in 32-bit words. Word indices at or above this value are out of range.
- AW, 32, byte address width from the core.

Ports:
- clk, input, 1, single clock; all state changes on rising edge.
- reset, input, 1, asynchronous active-high reset.
- req_valid, input, 1, core requests an access; held with all request fields stable until `done`.
- req_we, input, 1, 1 = store, 0 = load.
- req_funct3, input, 3, RV32I funct3 of the load or store.
- req_addr, input, AW, byte address.
- req_wdata, input, 32, store data (rs2).
- stall, output, 1, equals req_valid & ~done; the core holds its PC and request while high.
- done, output, 1, single-cycle pulse marking completion of the current request.
- load_data, output, 32, extended load result; valid only when done & ~req_we & ~err, otherwise 0.
- err, output, 1, pulses with `done` on a misaligned, illegal-funct3 or out-of-range access.
- mem_read, output, 1, to the memory's memread.
- mem_write, output, 1, to the memory's memwrite.
- mem_addr, output, 32, word index {2'b0, addr[31:2]}.
- mem_wdata, output, 32, word to write.
- mem_rdata, input, 32, registered memory read data: valid the cycle after mem_read, and 0 if mem_read was low.

Behaviour:
- Memory model: one-cycle registered read, synchronous full-word write, no byte enables.
- FSM states: IDLE, LD_DATA, ST_MERGE.
- The request is latched on acceptance: funct3, byte offset addr[1:0], word index, wdata.
- Reset values: while reset is high, state = IDLE, latched registers = 0, and every output is forced to 0. No memory access occurs during reset.
- Request checks, evaluated in IDLE when req_valid is high (priority: illegal > misaligned > range):
  - Illegal funct3:
    - loads: 3'b011, 3'b110, 3'b111;
    - stores: any value above 3'b010.
  - Misaligned:
    - halfword with addr[0] = 1;
    - word with addr[1:0] != 0.
  - Out of range: addr[31:2] >= MEM_WORDS.
- Any check fails: in the same cycle done = 1 and err = 1. No mem_read or mem_write is asserted; state stays IDLE.
- LW/LB/LH/LBU/LHU:
  - IDLE: mem_read = 1 combinationally, request latched, go to LD_DATA.
  - LD_DATA: select the byte or half from mem_rdata using the latched offset, then extend it.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - done = 1, then IDLE.
  - Total latency 2 cycles; stall is high for 1 cycle.
- SW (aligned):
  - IDLE: mem_write = 1, mem_wdata = req_wdata, done = 1 in the same cycle.
  - Zero stall.
- SB/SH:
  - IDLE: mem_read = 1, go to ST_MERGE.
  - ST_MERGE: mem_wdata = mem_rdata with the target lane replaced by req_wdata[7:0] or [15:0].
  - mem_write = 1, done = 1, then IDLE.
  - Latency 2 cycles.
- mem_read and mem_write are never high in the same cycle.
- req_valid low in IDLE: no memory activity; all outputs 0.
- Back-to-back requests: a new request may be accepted in the IDLE cycle right after done. No bubble is required beyond the FSM.
- Reset asserted in LD_DATA or ST_MERGE: the access is abandoned and state returns to IDLE. No write is issued, so a partial RMW never writes memory.
- req_valid dropping mid-operation is a protocol violation. The FSM completes on the latched request regardless.

Decomposition:
- Shared package lsu_pkg contains:
  - funct3 localparams F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  - the state enum lsu_state_t {IDLE, LD_DATA, ST_MERGE}.
- One combinational sub-module, lsu_align:
  - load path: lane extract plus sign/zero extension from (word, offset, funct3);
  - store path: lane merge from (old word, new data, offset, funct3).
- The FSM and checks live in load_store_unit.

Test Plan:
1. Preload word 1 = 0x8899AABB. LB addr 0x7 -> cycle 0: mem_read = 1, mem_addr = 1, stall = 1. Cycle 1: done = 1, load_data = 0xFFFFFF88.
2. Same word. LHU addr 0x6 -> load_data = 0x00008899. LH addr 0x4 -> load_data = 0xFFFFAABB. LW addr 0x4 -> load_data = 0x8899AABB.
3. SB addr 0x5 wdata 0x00000123 -> cycle 0: mem_read = 1. Cycle 1: mem_write = 1, mem_wdata = 0x889923BB. A following LW addr 0x4 returns 0x889923BB.
4. LH addr 0x3, SW addr 0x6, and a load with funct3 = 3'b111 -> each gives done = err = 1 in the same cycle, mem_read = mem_write = 0, stall = 0.
5. LW addr 0x100 with MEM_WORDS = 64 -> err = 1, no memory access. LW addr 0xFC -> normal access to word 63.
6. SH addr 0x2 with reset asserted during ST_MERGE -> mem_write never goes high and the memory word is unchanged. After reset release, state is IDLE and all outputs are 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        LD_DATA,
        ST_MERGE
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extract with sign/zero extension, and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (funct3)
            F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_ext = {24'h0, shifted[7:0]};
            F3_HU:   load_ext = {16'h0, shifted[15:0]};
            default: load_ext = word;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_B: begin
                lane_mask = 32'h0000_00FF << {offset, 3'b000};
                lane_data = {24'h0, wdata[7:0]} << {offset, 3'b000};
            end
            F3_H: begin
                lane_mask = 32'h0000_FFFF << {offset[1], 4'b0000};
                lane_data = {16'h0, wdata[15:0]} << {offset[1], 4'b0000};
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = wdata;
            end
        endcase
        merged = (word & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit for a word-organised memory with one-cycle registered reads.
// Sub-word stores are done as read-modify-write; stall freezes the core while busy.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          stall,
    output logic          done,
    output logic [31:0]   load_data,
    output logic          err,
    output logic          mem_read,
    output logic          mem_write,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    lsu_state_t  state, state_nxt;
    logic [2:0]  f3_p1;
    logic [1:0]  off_p1;
    logic [31:0] idx_p1;
    logic [31:0] wdata_p1;
    logic        latch;
    logic        illegal, misaligned, out_of_range, chk_err;
    logic [31:0] req_idx;
    logic [31:0] ld_ext, st_merged;

    assign req_idx      = 32'(req_addr[AW-1:2]);
    assign out_of_range = {2'b00, req_addr[AW-1:2]} >= AW'(MEM_WORDS);
    assign chk_err      = illegal | misaligned | out_of_range;

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (req_we) begin
            illegal = req_funct3 > F3_W;
        end else begin
            illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        end
        case (req_funct3)
            F3_H, F3_HU: misaligned = req_addr[0];
            F3_W:        misaligned = |req_addr[1:0];
            default:     misaligned = 1'b0;
        endcase
    end

    lsu_align u_align (
        .word     (mem_rdata),
        .offset   (off_p1),
        .funct3   (f3_p1),
        .wdata    (wdata_p1),
        .load_ext (ld_ext),
        .merged   (st_merged)
    );

    // Outputs are held at zero throughout reset so no access escapes.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        done      = 1'b0;
        err       = 1'b0;
        load_data = 32'h0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (chk_err) begin
                            done = 1'b1;
                            err  = 1'b1;
                        end else if (!req_we) begin
                            mem_read  = 1'b1;
                            mem_addr  = req_idx;
                            latch     = 1'b1;
                            state_nxt = LD_DATA;
                        end else if (req_funct3 == F3_W) begin
                            mem_write = 1'b1;
                            mem_addr  = req_idx;
                            mem_wdata = req_wdata;
                            done      = 1'b1;
                        end else begin
                            mem_read  = 1'b1;
                            mem_addr  = req_idx;
                            latch     = 1'b1;
                            state_nxt = ST_MERGE;
                        end
                    end
                end
                LD_DATA: begin
                    done      = 1'b1;
                    load_data = ld_ext;
                    state_nxt = IDLE;
                end
                ST_MERGE: begin
                    mem_write = 1'b1;
                    mem_addr  = idx_p1;
                    mem_wdata = st_merged;
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign stall = req_valid & ~done & ~reset;

    // Request capture stage: completion uses only these copies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            f3_p1    <= 3'h0;
            off_p1   <= 2'h0;
            idx_p1   <= 32'h0;
            wdata_p1 <= 32'h0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                f3_p1    <= req_funct3;
                off_p1   <= req_addr[1:0];
                idx_p1   <= req_idx;
                wdata_p1 <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with scoreboard, plus reset corner cases.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall, done, err, mem_read, mem_write;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .AW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .done       (done),
        .load_data  (load_data),
        .err        (err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    logic [31:0] mem [MEM_WORDS];
    int          wr_count = 0;

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[5:0]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        mem_rdata <= mem_read ? mem[mem_addr[5:0]] : 32'h0;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
        logic [31:0] exp_wdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic e, logic [31:0] d, logic [31:0] wd, int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_err = e; v.exp_data = d; v.exp_wdata = wd; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        bit   got;
        vec_t s;
        logic exp_rd, exp_wr0;
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        sb.push_back(v);
        cyc = 0;
        got = 0;
        exp_rd  = !v.exp_err && (!v.we || v.f3 != F3_W);
        exp_wr0 = !v.exp_err && v.we && v.f3 == F3_W;
        while (!got && cyc <= 3) begin
            @(negedge clk);
            if (mem_read && mem_write) chk($sformatf("rd_wr_excl[%0d]", idx), 32'(mem_write), 32'd0);
            if (cyc == 0) begin
                chk($sformatf("mem_read[%0d]", idx), 32'(mem_read), 32'(exp_rd));
                chk($sformatf("mem_write0[%0d]", idx), 32'(mem_write), 32'(exp_wr0));
                chk($sformatf("stall[%0d]", idx), 32'(stall), 32'(!v.exp_err && v.exp_lat == 1));
                if (!v.exp_err) chk($sformatf("mem_addr[%0d]", idx), mem_addr, v.addr >> 2);
            end
            if (done) begin
                got = 1;
                s = sb.pop_front();
                chk($sformatf("err[%0d]", idx), 32'(err), 32'(s.exp_err));
                chk($sformatf("load_data[%0d]", idx), load_data, s.exp_data);
                chk($sformatf("latency[%0d]", idx), 32'(cyc), 32'(s.exp_lat));
                if (s.we && !s.exp_err) begin
                    chk($sformatf("mem_write[%0d]", idx), 32'(mem_write), 32'd1);
                    chk($sformatf("mem_wdata[%0d]", idx), mem_wdata, s.exp_wdata);
                end
            end else begin
                cyc++;
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            s = sb.pop_front();
            chk($sformatf("timeout[%0d]", idx), 32'(got), 32'd1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int wr_before;

        vecs.push_back(mk(1, F3_W,   32'h04, 32'h8899AABB, 0, 0, 32'h8899AABB, 0));
        vecs.push_back(mk(1, F3_W,   32'hFC, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0));
        vecs.push_back(mk(1, F3_W,   32'h08, 32'h11223344, 0, 0, 32'h11223344, 0));
        vecs.push_back(mk(1, F3_W,   32'h00, 32'h00000000, 0, 0, 32'h00000000, 0));
        vecs.push_back(mk(0, F3_B,   32'h07, 0, 0, 32'hFFFFFF88, 0, 1));
        vecs.push_back(mk(0, F3_BU,  32'h07, 0, 0, 32'h00000088, 0, 1));
        vecs.push_back(mk(0, F3_HU,  32'h06, 0, 0, 32'h00008899, 0, 1));
        vecs.push_back(mk(0, F3_H,   32'h04, 0, 0, 32'hFFFFAABB, 0, 1));
        vecs.push_back(mk(0, F3_W,   32'h04, 0, 0, 32'h8899AABB, 0, 1));
        vecs.push_back(mk(0, F3_B,   32'h04, 0, 0, 32'hFFFFFFBB, 0, 1));
        vecs.push_back(mk(0, F3_BU,  32'h05, 0, 0, 32'h000000AA, 0, 1));
        vecs.push_back(mk(1, F3_B,   32'h05, 32'h00000123, 0, 0, 32'h889923BB, 1));
        vecs.push_back(mk(0, F3_W,   32'h04, 0, 0, 32'h889923BB, 0, 1));
        vecs.push_back(mk(1, F3_H,   32'h0A, 32'hDEADBEEF, 0, 0, 32'hBEEF3344, 1));
        vecs.push_back(mk(0, F3_W,   32'h08, 0, 0, 32'hBEEF3344, 0, 1));
        vecs.push_back(mk(0, F3_H,   32'h0A, 0, 0, 32'hFFFFBEEF, 0, 1));
        vecs.push_back(mk(0, F3_B,   32'h09, 0, 0, 32'h00000033, 0, 1));
        vecs.push_back(mk(1, F3_B,   32'h03, 32'h000000AB, 0, 0, 32'hAB000000, 1));
        vecs.push_back(mk(0, F3_W,   32'h00, 0, 0, 32'hAB000000, 0, 1));
        vecs.push_back(mk(0, F3_H,   32'h03, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, F3_W,   32'h06, 32'h12345678, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3'b111, 32'h04, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3'b011, 32'h04, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b011, 32'h04, 32'h1, 1, 0, 0, 0));
        vecs.push_back(mk(0, F3_W,   32'h100, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, F3_H,   32'h101, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, F3_B,   32'h104, 32'h5A, 1, 0, 0, 0));
        vecs.push_back(mk(0, F3_W,   32'hFC, 0, 0, 32'hCAFEF00D, 0, 1));
        vecs.push_back(mk(0, F3_HU,  32'hFE, 0, 0, 32'h0000CAFE, 0, 1));
        vecs.push_back(mk(0, F3_B,   32'hFE, 0, 0, 32'hFFFFFFFE, 0, 1));
        vecs.push_back(mk(1, F3_H,   32'hFC, 32'h00001234, 0, 0, 32'hCAFE1234, 1));
        vecs.push_back(mk(0, F3_W,   32'hFC, 0, 0, 32'hCAFE1234, 0, 1));

        // Reset with a request pending: every output must stay zero.
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h4;
        req_wdata  = 32'h0;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_mem_read", 32'(mem_read), 32'd0);
        chk("idle_mem_write", 32'(mem_write), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i], i);
        req_valid = 1'b0;
        @(posedge clk); #1;

        // SH abandoned by reset during the merge cycle: memory must not change.
        wr_before  = wr_count;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_H;
        req_addr   = 32'h2;
        req_wdata  = 32'h00005555;
        @(negedge clk);
        chk("abort_mem_read", 32'(mem_read), 32'd1);
        chk("abort_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_read", 32'(mem_read), 32'd0);
        chk("post_rst_mem_write", 32'(mem_write), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        chk("abort_write_count", 32'(wr_count - wr_before), 32'd0);
        chk("abort_mem_word", mem[0], 32'hAB000000);
        run_vec(mk(0, F3_W, 32'h00, 0, 0, 32'hAB000000, 0, 1), 100);
        run_vec(mk(0, F3_HU, 32'h02, 0, 0, 32'h0000AB00, 0, 1), 101);
        req_valid = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
